// File: rtl/board_pkg.sv
// Shared constants, types and addressing helpers for the Connect-6 board storage
// and the units that read from or write to it.
package board_pkg;

    localparam int BOARD_SIZE = 19;
    localparam int COORD_W    = 5;
    localparam int NUM_CELLS  = BOARD_SIZE * BOARD_SIZE;
    localparam int IDX_W      = $clog2(NUM_CELLS);

    typedef logic [1:0]         cell_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   cell_idx_t;

    localparam cell_t  EMPTY_CODE  = 2'b00;
    localparam cell_t  BORDER_CODE = 2'b11;
    localparam cell_t  STONE_BLACK = 2'b01;
    localparam cell_t  STONE_WHITE = 2'b10;
    localparam coord_t BOARD_LIMIT = coord_t'(BOARD_SIZE);

    function automatic logic on_board(coord_t x, coord_t y);
        return (x < BOARD_LIMIT) && (y < BOARD_LIMIT);
    endfunction

    // Row-major flattening: index = y * BOARD_SIZE + x.
    function automatic cell_idx_t cell_index(coord_t x, coord_t y);
        return cell_idx_t'(y) * cell_idx_t'(BOARD_SIZE) + cell_idx_t'(x);
    endfunction

endpackage

// File: rtl/board_read_port.sv
// One registered read port onto the board: bounds check, cell select and output flop.
// Off-board coordinates return BORDER_CODE so the scanners see a wall.
module board_read_port
    import board_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      read_i,
    input  cell_t [NUM_CELLS-1:0]     cells_i,
    input  logic  [COORD_W-1:0]       x_i,
    input  logic  [COORD_W-1:0]       y_i,
    output logic  [1:0]               data_o
);

    cell_t data_q;
    cell_t data_d;

    always_comb begin
        data_d = data_q;
        if (read_i) begin
            if (on_board(x_i, y_i)) begin
                data_d = cells_i[cell_index(x_i, y_i)];
            end else begin
                data_d = BORDER_CODE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= EMPTY_CODE;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/board_memory.sv
// Flop-based Connect-6 board: one write port for the controller and four
// independent registered read ports for the line scanners.
module board_memory
    import board_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 READ,
    input  logic                 WRITE,
    input  logic [COORD_W-1:0]   Xloc,
    input  logic [COORD_W-1:0]   Yloc,
    input  logic [1:0]           dataIN,
    input  logic [COORD_W-1:0]   XlocV,
    input  logic [COORD_W-1:0]   YlocV,
    input  logic [COORD_W-1:0]   XlocH,
    input  logic [COORD_W-1:0]   YlocH,
    input  logic [COORD_W-1:0]   XlocNE,
    input  logic [COORD_W-1:0]   YlocNE,
    input  logic [COORD_W-1:0]   XlocNW,
    input  logic [COORD_W-1:0]   YlocNW,
    output logic [1:0]           verticleDataOUT,
    output logic [1:0]           horizontalDataOUT,
    output logic [1:0]           NEDataOUT,
    output logic [1:0]           NWDataOUT
);

    cell_t [NUM_CELLS-1:0] board_q;
    cell_t [NUM_CELLS-1:0] board_d;

    always_comb begin
        board_d = board_q;
        if (WRITE && on_board(Xloc, Yloc)) begin
            board_d[cell_index(Xloc, Yloc)] = dataIN;
        end
    end

    // Readers see board_q, so a same-cycle write to the read cell returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            board_q <= {NUM_CELLS{EMPTY_CODE}};
        end else begin
            board_q <= board_d;
        end
    end

    board_read_port u_port_v (
        .clk     (clk),
        .reset   (reset),
        .read_i  (READ),
        .cells_i (board_q),
        .x_i     (XlocV),
        .y_i     (YlocV),
        .data_o  (verticleDataOUT)
    );

    board_read_port u_port_h (
        .clk     (clk),
        .reset   (reset),
        .read_i  (READ),
        .cells_i (board_q),
        .x_i     (XlocH),
        .y_i     (YlocH),
        .data_o  (horizontalDataOUT)
    );

    board_read_port u_port_ne (
        .clk     (clk),
        .reset   (reset),
        .read_i  (READ),
        .cells_i (board_q),
        .x_i     (XlocNE),
        .y_i     (YlocNE),
        .data_o  (NEDataOUT)
    );

    board_read_port u_port_nw (
        .clk     (clk),
        .reset   (reset),
        .read_i  (READ),
        .cells_i (board_q),
        .x_i     (XlocNW),
        .y_i     (YlocNW),
        .data_o  (NWDataOUT)
    );

endmodule

// File: tb/tb_board_memory.sv
// Bench for board_memory: a hand-computed vector table for the directed scenarios,
// followed by random traffic checked against a 2-D array model of the board.
module tb_board_memory;

    typedef struct {
        logic       rst, rd, wr;
        logic [4:0] wx, wy;
        logic [1:0] din;
        logic [4:0] vx, vy, hx, hy, nex, ney, nwx, nwy;
        logic [1:0] ev, eh, ene, enw;
    } vec_t;

    localparam int N = 19;
    localparam int NUM_VECS = 21;
    localparam int NUM_RANDOM = 600;

    logic       clk = 1'b0;
    logic       reset, READ, WRITE;
    logic [4:0] Xloc, Yloc;
    logic [1:0] dataIN;
    logic [4:0] XlocV, YlocV, XlocH, YlocH, XlocNE, YlocNE, XlocNW, YlocNW;
    logic [1:0] verticleDataOUT, horizontalDataOUT, NEDataOUT, NWDataOUT;

    int compared = 0;
    int mismatched = 0;

    logic [1:0] mBoard [N][N];
    logic [1:0] mOut [4];

    vec_t vecs [NUM_VECS];

    always #5 clk = ~clk;

    board_memory dut (
        .clk               (clk),
        .reset             (reset),
        .READ              (READ),
        .WRITE             (WRITE),
        .Xloc              (Xloc),
        .Yloc              (Yloc),
        .dataIN            (dataIN),
        .XlocV             (XlocV),
        .YlocV             (YlocV),
        .XlocH             (XlocH),
        .YlocH             (YlocH),
        .XlocNE            (XlocNE),
        .YlocNE            (YlocNE),
        .XlocNW            (XlocNW),
        .YlocNW            (YlocNW),
        .verticleDataOUT   (verticleDataOUT),
        .horizontalDataOUT (horizontalDataOUT),
        .NEDataOUT         (NEDataOUT),
        .NWDataOUT         (NWDataOUT)
    );

    function automatic vec_t mkVec(int r, int rd, int wr, int wx, int wy, int din,
                                   int vx, int vy, int hx, int hy,
                                   int nex, int ney, int nwx, int nwy,
                                   int ev, int eh, int ene, int enw);
        vec_t v;
        v.rst = 1'(r);   v.rd = 1'(rd);   v.wr = 1'(wr);
        v.wx = 5'(wx);   v.wy = 5'(wy);   v.din = 2'(din);
        v.vx = 5'(vx);   v.vy = 5'(vy);   v.hx = 5'(hx);   v.hy = 5'(hy);
        v.nex = 5'(nex); v.ney = 5'(ney); v.nwx = 5'(nwx); v.nwy = 5'(nwy);
        v.ev = 2'(ev);   v.eh = 2'(eh);   v.ene = 2'(ene); v.enw = 2'(enw);
        return v;
    endfunction

    function automatic logic [1:0] modelRead(logic [4:0] x, logic [4:0] y);
        if (int'(x) >= N || int'(y) >= N) return 2'b11;
        return mBoard[x][y];
    endfunction

    // Reads sample the board before the write lands, matching read-before-write.
    task automatic modelStep(vec_t v);
        if (v.rst) begin
            for (int x = 0; x < N; x++)
                for (int y = 0; y < N; y++)
                    mBoard[x][y] = 2'b00;
            for (int p = 0; p < 4; p++) mOut[p] = 2'b00;
        end else begin
            if (v.rd) begin
                mOut[0] = modelRead(v.vx, v.vy);
                mOut[1] = modelRead(v.hx, v.hy);
                mOut[2] = modelRead(v.nex, v.ney);
                mOut[3] = modelRead(v.nwx, v.nwy);
            end
            if (v.wr && int'(v.wx) < N && int'(v.wy) < N) mBoard[v.wx][v.wy] = v.din;
        end
    endtask

    task automatic applyStimulus(vec_t v);
        reset = v.rst;  READ = v.rd;   WRITE = v.wr;
        Xloc = v.wx;    Yloc = v.wy;   dataIN = v.din;
        XlocV = v.vx;   YlocV = v.vy;  XlocH = v.hx;   YlocH = v.hy;
        XlocNE = v.nex; YlocNE = v.ney; XlocNW = v.nwx; YlocNW = v.nwy;
        @(posedge clk);
        modelStep(v);
        #1;
    endtask

    task automatic checkOutput(string name, logic [1:0] act, logic [1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] randCoord();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'($urandom_range(19, 31));
        if (r < 5)  return 5'($urandom_range(0, 4));
        return 5'($urandom_range(0, 18));
    endfunction

    initial begin
        vec_t v;

        //               rst rd wr  wx wy din  vx vy  hx hy  nex ney nwx nwy   ev eh ene enw
        vecs[0]  = mkVec(1, 1, 0,   0, 0, 0,   0, 0,  18,18, 9, 9,  18, 0,    0, 0, 0, 0);
        vecs[1]  = mkVec(0, 1, 0,   0, 0, 0,   0, 0,  18,18, 9, 9,  18, 0,    0, 0, 0, 0);
        vecs[2]  = mkVec(0, 0, 1,   3, 7, 2,   0, 0,  0, 0,  0, 0,  0, 0,     0, 0, 0, 0);
        vecs[3]  = mkVec(0, 1, 1,   19,5, 1,   3, 7,  7, 3,  19,5,  5, 25,    2, 0, 3, 3);
        vecs[4]  = mkVec(0, 1, 0,   0, 0, 0,   18,5,  0, 6,  3, 7,  0, 0,     0, 0, 2, 0);
        vecs[5]  = mkVec(0, 0, 1,   10,10,1,   0, 0,  0, 0,  0, 0,  0, 0,     0, 0, 2, 0);
        vecs[6]  = mkVec(0, 1, 1,   10,10,2,   10,10, 10,10, 10,10, 10,10,    1, 1, 1, 1);
        vecs[7]  = mkVec(0, 1, 0,   0, 0, 0,   10,10, 10,10, 10,10, 10,10,    2, 2, 2, 2);
        vecs[8]  = mkVec(0, 0, 1,   2, 2, 1,   0, 0,  0, 0,  0, 0,  0, 0,     2, 2, 2, 2);
        vecs[9]  = mkVec(0, 1, 0,   0, 0, 0,   2, 2,  3, 7,  31,31, 2, 2,     1, 2, 3, 1);
        vecs[10] = mkVec(0, 0, 1,   2, 2, 2,   2, 2,  3, 7,  31,31, 2, 2,     1, 2, 3, 1);
        vecs[11] = mkVec(0, 0, 0,   0, 0, 0,   2, 2,  3, 7,  31,31, 2, 2,     1, 2, 3, 1);
        vecs[12] = mkVec(0, 1, 0,   0, 0, 0,   2, 2,  3, 7,  31,31, 2, 2,     2, 2, 3, 2);
        vecs[13] = mkVec(0, 0, 1,   1, 1, 1,   0, 0,  0, 0,  0, 0,  0, 0,     2, 2, 3, 2);
        vecs[14] = mkVec(0, 0, 1,   17,3, 2,   0, 0,  0, 0,  0, 0,  0, 0,     2, 2, 3, 2);
        vecs[15] = mkVec(0, 0, 1,   5, 18,3,   0, 0,  0, 0,  0, 0,  0, 0,     2, 2, 3, 2);
        vecs[16] = mkVec(0, 1, 1,   18,18,1,   1, 1,  17,3,  5, 18, 18,18,    1, 2, 3, 0);
        vecs[17] = mkVec(0, 1, 0,   0, 0, 0,   1, 1,  17,3,  5, 18, 18,18,    1, 2, 3, 1);
        vecs[18] = mkVec(1, 1, 1,   0, 0, 1,   1, 1,  17,3,  5, 18, 18,18,    0, 0, 0, 0);
        vecs[19] = mkVec(0, 1, 0,   0, 0, 0,   1, 1,  17,3,  5, 18, 18,18,    0, 0, 0, 0);
        vecs[20] = mkVec(0, 1, 0,   0, 0, 0,   0, 0,  0, 0,  0, 0,  0, 0,     0, 0, 0, 0);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d V", i),  verticleDataOUT,   vecs[i].ev);
            checkOutput($sformatf("vec%0d H", i),  horizontalDataOUT, vecs[i].eh);
            checkOutput($sformatf("vec%0d NE", i), NEDataOUT,         vecs[i].ene);
            checkOutput($sformatf("vec%0d NW", i), NWDataOUT,         vecs[i].enw);
        end

        // Write a stone then hold WRITE for several cycles; the cell reads the same value after.
        v = mkVec(0, 0, 1, 18, 0, 2, 0,0,0,0,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 3; i++) applyStimulus(v);
        v = mkVec(0, 1, 0, 0, 0, 0, 18,0, 18,0, 0,18, 18,0, 0,0,0,0);
        applyStimulus(v);
        checkOutput("heldWrite V",  verticleDataOUT, 2'b10);
        checkOutput("heldWrite NE", NEDataOUT,       2'b00);

        for (int i = 0; i < NUM_RANDOM; i++) begin
            v = mkVec(($urandom_range(0, 63) == 0) ? 1 : 0,
                      int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                      int'(randCoord()), int'(randCoord()), int'($urandom_range(0, 3)),
                      int'(randCoord()), int'(randCoord()), int'(randCoord()), int'(randCoord()),
                      int'(randCoord()), int'(randCoord()), int'(randCoord()), int'(randCoord()),
                      0, 0, 0, 0);
            applyStimulus(v);
            checkOutput($sformatf("rand%0d V", i),  verticleDataOUT,   mOut[0]);
            checkOutput($sformatf("rand%0d H", i),  horizontalDataOUT, mOut[1]);
            checkOutput($sformatf("rand%0d NE", i), NEDataOUT,         mOut[2]);
            checkOutput($sformatf("rand%0d NW", i), NWDataOUT,         mOut[3]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
